mem_arbiter: RTL



---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared definitions for the two-client block memory arbiter and the caches
//   that sit on either side of it.
//   - ADDR_W_DEF / DATA_W_DEF : default block address / block data widths
//   - arb_state_t             : arbiter state encoding
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 28;   // block address (word address >> 2)
  localparam int DATA_W_DEF = 128;  // 4 x 32-bit words per block

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_I = 2'd1,
    S_BUSY_D = 2'd2,
    S_GAP    = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Merges the I-cache and D-cache block ports onto one 128-bit memory port.
//   Round-robin grant, registered memory command held until mem_ready, and a
//   single idle turnaround cycle between transactions.
//
// Ports
//   clk, proc_reset              : clock, synchronous active-high reset
//   i_mem_read / i_mem_addr      : I-cache read request (held until ready)
//   i_mem_rdata / i_mem_ready    : I-cache read data / completion pulse
//   d_mem_read / d_mem_write     : D-cache request (held until ready)
//   d_mem_addr / d_mem_wdata     : D-cache address / write data
//   d_mem_rdata / d_mem_ready    : D-cache read data / completion pulse
//   mem_read / mem_write         : registered command to memory
//   mem_addr / mem_wdata         : registered address / write data to memory
//   mem_rdata / mem_ready        : memory read data / completion pulse
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              proc_reset,
  // I-cache side
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  // D-cache side
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  // Memory side
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_t        r_state;
  logic              r_last_d;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic w_i_req;
  logic w_d_req;
  logic w_grant_d;

  // D wins when it is the only requester, or on a tie when I had the last grant.
  function automatic logic pick_d(input logic i_req, input logic d_req,
                                  input logic last_d);
    return d_req && (!i_req || !last_d);
  endfunction

  assign w_i_req   = i_mem_read;
  assign w_d_req   = d_mem_read || d_mem_write;
  assign w_grant_d = pick_d(w_i_req, w_d_req, r_last_d);

  // Read data is broadcast; each client qualifies it with its own ready.
  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;

  // Zero-latency completion: mem_ready is forwarded only to the owner of the
  // in-flight transaction, and suppressed while reset is asserted.
  assign i_mem_ready = !proc_reset && (r_state == S_BUSY_I) && mem_ready;
  assign d_mem_ready = !proc_reset && (r_state == S_BUSY_D) && mem_ready;

  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  // NOTE: state is updated with non-blocking assignments only, so every read of
  // r_* in this block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      r_state     <= S_IDLE;
      r_last_d    <= 1'b1;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_i_req || w_d_req) begin
            r_last_d <= w_grant_d;
            if (w_grant_d) begin
              r_state    <= S_BUSY_D;
              r_mem_addr <= d_mem_addr;
              // Read+write together is treated as a write.
              r_mem_write <= d_mem_write;
              r_mem_read  <= !d_mem_write;
              if (d_mem_write) begin
                r_mem_wdata <= d_mem_wdata;
              end
            end else begin
              r_state     <= S_BUSY_I;
              r_mem_addr  <= i_mem_addr;
              r_mem_read  <= 1'b1;
              r_mem_write <= 1'b0;
            end
          end
        end
        S_BUSY_I, S_BUSY_D: begin
          if (mem_ready) begin
            r_state     <= S_GAP;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
          end
        end
        S_GAP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
